// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
//   Shared constants for the true-dual-port block RAM and the clients that
//   drive its ports.
//   Contents:
//     RAM_ADDR_WIDTH / RAM_DATA_WIDTH / RAM_BYTE_WIDTH / RAM_READ_LATENCY
//       default geometry of the RAM
//     bytes_per_word() number of byte lanes (strobe bits) in one word
// ---------------------------------------------------------------------------
package ram_pkg;

   localparam int RAM_ADDR_WIDTH   = 17;
   localparam int RAM_DATA_WIDTH   = 64;
   localparam int RAM_BYTE_WIDTH   = 8;
   localparam int RAM_READ_LATENCY = 2;

   function automatic int bytes_per_word(input int data_width, input int byte_width);
      return data_width / byte_width;
   endfunction

endpackage

// File: rtl/ram_port_client_if.sv
// ---------------------------------------------------------------------------
// ram_port_client_if
//   Bundles the three faces of a RAM port client:
//     request stream   req_valid/req_ready/req_addr/req_strobe/req_wdata
//     response stream  resp_valid/resp_ready/resp_data
//     RAM port         ram_en/ram_addr/ram_strobe/ram_wdata/ram_rdata
//   Modports:
//     slave  - the client adapter (accepts requests, drives the RAM port)
//     master - the environment (issues requests, consumes responses and
//              plays the RAM)
// ---------------------------------------------------------------------------
interface ram_port_client_if
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = RAM_DATA_WIDTH,
   parameter int BYTE_WIDTH = RAM_BYTE_WIDTH
);

   localparam int STRB_WIDTH = bytes_per_word(DATA_WIDTH, BYTE_WIDTH);

   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [STRB_WIDTH-1:0] req_strobe;
   logic [DATA_WIDTH-1:0] req_wdata;

   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_data;

   logic                  ram_en;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [STRB_WIDTH-1:0] ram_strobe;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;

   modport slave (
      input  req_valid, req_addr, req_strobe, req_wdata,
      output req_ready,
      output resp_valid, resp_data,
      input  resp_ready,
      output ram_en, ram_addr, ram_strobe, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output req_valid, req_addr, req_strobe, req_wdata,
      input  req_ready,
      input  resp_valid, resp_data,
      output resp_ready,
      input  ram_en, ram_addr, ram_strobe, ram_wdata,
      output ram_rdata
   );

endinterface

// File: rtl/ram_port_client_resp_fifo.sv
// ---------------------------------------------------------------------------
// resp_fifo
//   Small synchronous in-order FIFO holding read responses. The head entry is
//   presented combinationally so a response is visible the cycle after it is
//   pushed into an empty FIFO.
//   Ports:
//     clk, resetn  clock, asynchronous active-low reset (pointers only)
//     push, din    write an entry (ignored while full)
//     pop          drop the head entry (ignored while empty)
//     dout         head entry
//     empty, full  occupancy flags
// ---------------------------------------------------------------------------
module resp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_wr;
   logic w_rd;

   assign empty = (r_count == '0);
   assign full  = (r_count == CNT_FULL);
   assign w_wr  = push & ~full;
   assign w_rd  = pop & ~empty;
   assign dout  = r_mem[r_rd_ptr];

   // Storage has no reset: stale entries are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
         end
         if (w_wr && !w_rd) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_wr && w_rd) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/ram_port_client.sv
// ---------------------------------------------------------------------------
// ram_port_client
//   Initiator-side adapter for one port of a read-first block RAM. Accepted
//   requests go straight out to the RAM port in the accept cycle; a flag pipe
//   matched to the RAM read latency marks which returning words are
//   responses, and those are queued in order in resp_fifo. A credit counter
//   reserves a FIFO slot for every response in flight so backpressure on the
//   response stream never loses data.
//   Ports:
//     clk     clock
//     resetn  asynchronous active-low reset
//     bus     ram_port_client_if.slave (request, response and RAM port)
// ---------------------------------------------------------------------------
module ram_port_client
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH   = RAM_ADDR_WIDTH,
   parameter int DATA_WIDTH   = RAM_DATA_WIDTH,
   parameter int BYTE_WIDTH   = RAM_BYTE_WIDTH,
   parameter int READ_LATENCY = RAM_READ_LATENCY,
   parameter int WRITE_RESP   = 1,
   parameter int RESP_DEPTH   = READ_LATENCY + 2
) (
   input  logic                clk,
   input  logic                resetn,
   ram_port_client_if.slave    bus
);

   localparam int STRB_WIDTH = bytes_per_word(DATA_WIDTH, BYTE_WIDTH);
   localparam int CRED_W     = $clog2(RESP_DEPTH + 1);
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RESP_DEPTH);

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [STRB_WIDTH-1:0] strobe_t;
   typedef logic [DATA_WIDTH-1:0] word_t;

   addr_t   w_addr;
   strobe_t w_strobe;
   word_t   w_wdata;
   word_t   w_resp_data;

   logic    w_expects;
   logic    w_accept;
   logic    w_credit_ok;
   logic    w_push;
   logic    w_pop;
   logic    w_fifo_empty;
   logic    w_fifo_full;

   logic [CRED_W-1:0] r_credit;

   assign w_addr   = bus.req_addr;
   assign w_strobe = bus.req_strobe;
   assign w_wdata  = bus.req_wdata;

   // Reads always answer; writes answer only when write responses are on.
   assign w_expects   = (w_strobe == '0) | (WRITE_RESP != 0);
   assign w_credit_ok = (r_credit < CRED_MAX);

   // A request that produces no response needs no FIFO slot, so it may pass
   // even with every credit taken. Gating with resetn keeps ready low while
   // reset is held.
   assign bus.req_ready = resetn & (w_credit_ok | ~w_expects);
   assign w_accept      = bus.req_valid & bus.req_ready;

   assign bus.ram_en     = w_accept;
   assign bus.ram_addr   = w_addr;
   assign bus.ram_strobe = w_accept ? w_strobe : '0;
   assign bus.ram_wdata  = w_wdata;

   // Latency pipe: bit gi is the expects-response flag of the access issued
   // gi+1 cycles ago; the last stage lines up with ram_rdata.
   generate
      if (READ_LATENCY == 0) begin : g_no_pipe
         assign w_push = w_accept & w_expects;
      end else begin : g_pipe
         logic [READ_LATENCY-1:0] r_pipe;
         logic [READ_LATENCY-1:0] w_pipe_next;

         for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_first
               assign w_pipe_next[gi] = w_accept & w_expects;
            end else begin : g_next
               assign w_pipe_next[gi] = r_pipe[gi-1];
            end
         end

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               r_pipe <= '0;
            end else begin
               r_pipe <= w_pipe_next;
            end
         end

         assign w_push = r_pipe[READ_LATENCY-1];
      end
   endgenerate

   assign w_pop = ~w_fifo_empty & bus.resp_ready;

   // Credit = responses in the pipe plus responses queued.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_credit <= '0;
      end else if ((w_accept & w_expects) && !w_pop) begin
         r_credit <= r_credit + CRED_W'(1);
      end else if (!(w_accept & w_expects) && w_pop) begin
         r_credit <= r_credit - CRED_W'(1);
      end
   end

   resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (w_push),
      .pop    (w_pop),
      .din    (bus.ram_rdata),
      .dout   (w_resp_data),
      .empty  (w_fifo_empty),
      .full   (w_fifo_full)
   );

   assign bus.resp_valid = ~w_fifo_empty;
   assign bus.resp_data  = w_resp_data;

   // The credit counter makes a push into a full FIFO unreachable.
   a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
      !(w_push && w_fifo_full));

endmodule

// File: tb/tb_ram_port_client.sv
module tb_ram_port_client;
   import ram_pkg::*;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   ram_port_client_if bus_a ();
   ram_port_client_if bus_b ();

   ram_port_client dut_a (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_a)
   );

   ram_port_client #(
      .WRITE_RESP (0)
   ) dut_b (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_b)
   );

   int vectors    = 0;
   int miscompares = 0;

   function automatic logic [63:0] pat(input int a);
      return {32'hDEAD_BEEF, 32'(a)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Read-first RAM models, latency 2, indexed by the low address byte.
   logic [63:0] mem_a [256];
   logic [63:0] mem_b [256];
   logic [63:0] st_a [2];
   logic [63:0] st_b [2];
   assign bus_a.ram_rdata = st_a[1];
   assign bus_b.ram_rdata = st_b[1];

   always @(posedge clk) begin
      if (bus_a.ram_en) begin
         st_a[0] <= mem_a[bus_a.ram_addr[7:0]];
         for (int b = 0; b < 8; b++)
            if (bus_a.ram_strobe[b]) mem_a[bus_a.ram_addr[7:0]][b*8 +: 8] <= bus_a.ram_wdata[b*8 +: 8];
      end
      st_a[1] <= st_a[0];
      if (bus_b.ram_en) begin
         st_b[0] <= mem_b[bus_b.ram_addr[7:0]];
         for (int b = 0; b < 8; b++)
            if (bus_b.ram_strobe[b]) mem_b[bus_b.ram_addr[7:0]][b*8 +: 8] <= bus_b.ram_wdata[b*8 +: 8];
      end
      st_b[1] <= st_b[0];
   end

   // FIFO protocol monitor.
   always @(negedge clk) begin
      if (resetn) begin
         if (dut_a.u_fifo.push && dut_a.u_fifo.full) begin
            miscompares++; $display("FAIL fifo_a_overflow: push=1 while full=1");
         end
         if (dut_a.u_fifo.pop && dut_a.u_fifo.empty) begin
            miscompares++; $display("FAIL fifo_a_underflow: pop=1 while empty=1");
         end
         if (dut_b.u_fifo.push && dut_b.u_fifo.full) begin
            miscompares++; $display("FAIL fifo_b_overflow: push=1 while full=1");
         end
         if (dut_b.u_fifo.pop && dut_b.u_fifo.empty) begin
            miscompares++; $display("FAIL fifo_b_underflow: pop=1 while empty=1");
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        v;
      logic [16:0] addr;
      logic [7:0]  strb;
      logic [63:0] wdata;
      logic        rr;
      logic        e_rdy;
      logic        e_en;
      logic [7:0]  e_strb;
      logic        e_rv;
      logic [63:0] e_data;
   } vec_t;

   vec_t tbl [10];

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   initial begin
      int acc;
      int issued;
      int got;
      int stalls;
      logic [63:0] exp_b [5];

      for (int i = 0; i < 256; i++) begin
         mem_a[i] = pat(i);
         mem_b[i] = pat(i);
      end
      mem_a[5] = 64'h0;

      //           v  addr     strb   wdata                    rr rdy en estrb rv data
      tbl[0] = '{1'b1, 17'h10, 8'h00, 64'h0,                   1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 64'h0};
      tbl[1] = '{1'b0, 17'h10, 8'hFF, 64'h0,                   1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 64'h0};
      tbl[2] = '{1'b0, 17'h0,  8'h00, 64'h0,                   1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 64'h0};
      tbl[3] = '{1'b0, 17'h0,  8'h00, 64'h0,                   1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 64'hDEAD_BEEF_0000_0010};
      tbl[4] = '{1'b1, 17'h5,  8'h0F, 64'h1111_2222_3333_4444, 1'b1, 1'b1, 1'b1, 8'h0F, 1'b0, 64'h0};
      tbl[5] = '{1'b1, 17'h5,  8'h00, 64'h0,                   1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 64'h0};
      tbl[6] = '{1'b0, 17'h0,  8'h00, 64'h0,                   1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 64'h0};
      tbl[7] = '{1'b0, 17'h0,  8'h00, 64'h0,                   1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 64'h0};
      tbl[8] = '{1'b0, 17'h0,  8'h00, 64'h0,                   1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 64'h0000_0000_3333_4444};
      tbl[9] = '{1'b0, 17'h0,  8'h00, 64'h0,                   1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 64'h0};

      // Reset state with requests pending on both ports.
      resetn = 1'b0;
      bus_a.req_valid = 1'b1; bus_a.req_addr = '0; bus_a.req_strobe = '0; bus_a.req_wdata = '0;
      bus_a.resp_ready = 1'b1;
      bus_b.req_valid = 1'b1; bus_b.req_addr = '0; bus_b.req_strobe = '0; bus_b.req_wdata = '0;
      bus_b.resp_ready = 1'b0;
      @(negedge clk);
      check("rst_a_ready", 64'(bus_a.req_ready), 64'd0);
      check("rst_a_en",    64'(bus_a.ram_en),    64'd0);
      check("rst_a_rv",    64'(bus_a.resp_valid), 64'd0);
      check("rst_b_ready", 64'(bus_b.req_ready), 64'd0);
      check("rst_b_rv",    64'(bus_b.resp_valid), 64'd0);
      next_cycle();
      next_cycle();
      resetn = 1'b1;
      bus_b.req_valid = 1'b0;

      // Tests 1 and 2: table-driven single read, then write + read-after-write.
      for (int i = 0; i < 10; i++) begin
         bus_a.req_valid  = tbl[i].v;
         bus_a.req_addr   = tbl[i].addr;
         bus_a.req_strobe = tbl[i].strb;
         bus_a.req_wdata  = tbl[i].wdata;
         bus_a.resp_ready = tbl[i].rr;
         @(negedge clk);
         check($sformatf("v%0d_ready", i), 64'(bus_a.req_ready),  64'(tbl[i].e_rdy));
         check($sformatf("v%0d_en", i),    64'(bus_a.ram_en),     64'(tbl[i].e_en));
         check($sformatf("v%0d_strb", i),  64'(bus_a.ram_strobe), 64'(tbl[i].e_strb));
         if (tbl[i].e_en) begin
            check($sformatf("v%0d_addr", i),  64'(bus_a.ram_addr), 64'(tbl[i].addr));
            check($sformatf("v%0d_wdata", i), bus_a.ram_wdata,     tbl[i].wdata);
         end
         check($sformatf("v%0d_rv", i), 64'(bus_a.resp_valid), 64'(tbl[i].e_rv));
         if (tbl[i].e_rv) check($sformatf("v%0d_data", i), bus_a.resp_data, tbl[i].e_data);
         $display("vector %0d: v=%0d addr=%h strb=%h rdy=%0d en=%0d rv=%0d data=%h",
                  i, tbl[i].v, tbl[i].addr, tbl[i].strb, bus_a.req_ready, bus_a.ram_en,
                  bus_a.resp_valid, bus_a.resp_data);
         next_cycle();
      end

      // Test 3: credit exhaustion under backpressure.
      bus_a.resp_ready = 1'b0;
      bus_a.req_strobe = '0;
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         bus_a.req_valid = 1'b1;
         bus_a.req_addr  = 17'(32'h20 + acc);
         @(negedge clk);
         if (bus_a.req_ready) acc++;
         next_cycle();
      end
      bus_a.req_valid = 1'b0;
      check("bp_accepted", 64'(acc), 64'd4);
      @(negedge clk);
      check("bp_ready_low", 64'(bus_a.req_ready), 64'd0);
      next_cycle();
      bus_a.resp_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check($sformatf("bp_rv%0d", j),   64'(bus_a.resp_valid), 64'd1);
         check($sformatf("bp_data%0d", j), bus_a.resp_data, pat(32'h20 + j));
         if (j == 0) check("bp_ready_at_pop",    64'(bus_a.req_ready), 64'd0);
         if (j == 1) check("bp_ready_after_pop", 64'(bus_a.req_ready), 64'd1);
         $display("backpressure resp %0d: data=%h ready=%0d", j, bus_a.resp_data, bus_a.req_ready);
         next_cycle();
      end
      @(negedge clk);
      check("bp_drained", 64'(bus_a.resp_valid), 64'd0);
      next_cycle();

      // Test 4: 100 back-to-back reads at full throughput.
      issued = 0; got = 0; stalls = 0;
      for (int c = 0; c < 140 && got < 100; c++) begin
         bus_a.req_valid = (issued < 100);
         bus_a.req_addr  = 17'(issued);
         @(negedge clk);
         if (issued < 100) begin
            if (!bus_a.req_ready) stalls++;
            else issued++;
         end
         if (bus_a.resp_valid) begin
            check($sformatf("stream_data%0d", got), bus_a.resp_data,
                  (got == 5) ? 64'h0000_0000_3333_4444 : pat(got));
            got++;
         end
         next_cycle();
      end
      bus_a.req_valid = 1'b0;
      check("stream_count", 64'(got), 64'd100);
      check("stream_stalls", 64'(stalls), 64'd0);
      $display("stream: issued=%0d responses=%0d stalls=%0d", issued, got, stalls);

      // Test 5: no-response write passes with credit exhausted (port B).
      for (int k = 0; k < 4; k++) begin
         bus_b.req_valid = 1'b1; bus_b.req_addr = 17'(32'h30 + k); bus_b.req_strobe = '0;
         @(negedge clk);
         check($sformatf("nr_fill%0d", k), 64'(bus_b.req_ready), 64'd1);
         next_cycle();
      end
      bus_b.req_addr = 17'h40; bus_b.req_strobe = 8'hFF; bus_b.req_wdata = 64'hCAFE_F00D_1234_5678;
      @(negedge clk);
      check("nr_wr_ready", 64'(bus_b.req_ready), 64'd1);
      check("nr_wr_en",    64'(bus_b.ram_en),    64'd1);
      $display("no-resp write: ready=%0d en=%0d strb=%h", bus_b.req_ready, bus_b.ram_en, bus_b.ram_strobe);
      next_cycle();
      bus_b.req_strobe = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("nr_rd_stall%0d", k), 64'(bus_b.req_ready), 64'd0);
         next_cycle();
      end
      exp_b[0] = pat(32'h30); exp_b[1] = pat(32'h31); exp_b[2] = pat(32'h32); exp_b[3] = pat(32'h33);
      exp_b[4] = 64'hCAFE_F00D_1234_5678;
      bus_b.resp_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 20; c++) begin
         logic acc_now;
         @(negedge clk);
         acc_now = bus_b.req_valid & bus_b.req_ready;
         if (bus_b.resp_valid) begin
            if (got < 5) check($sformatf("nr_resp%0d", got), bus_b.resp_data, exp_b[got]);
            else begin
               miscompares++;
               $display("FAIL nr_extra: got unexpected response %h", bus_b.resp_data);
            end
            got++;
         end
         next_cycle();
         if (acc_now) bus_b.req_valid = 1'b0;
      end
      bus_b.req_valid = 1'b0;
      check("nr_resp_count", 64'(got), 64'd5);
      $display("no-resp: responses=%0d", got);

      // Test 6: reset with two reads in flight and one response queued.
      bus_a.resp_ready = 1'b0; bus_a.req_strobe = '0;
      bus_a.req_valid = 1'b1; bus_a.req_addr = 17'h50; next_cycle();
      bus_a.req_valid = 1'b0;                           next_cycle();
      bus_a.req_valid = 1'b1; bus_a.req_addr = 17'h51; next_cycle();
      bus_a.req_addr = 17'h52;                          next_cycle();
      bus_a.req_addr = 17'h60;
      check("mr_queued_rv", 64'(bus_a.resp_valid), 64'd1);
      resetn = 1'b0;
      #1;
      check("mr_rv_now",    64'(bus_a.resp_valid), 64'd0);
      check("mr_ready_now", 64'(bus_a.req_ready),  64'd0);
      check("mr_en_now",    64'(bus_a.ram_en),     64'd0);
      next_cycle();
      next_cycle();
      resetn = 1'b1;
      bus_a.req_valid = 1'b0; bus_a.resp_ready = 1'b1;
      stalls = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus_a.resp_valid) stalls++;
         next_cycle();
      end
      check("mr_no_stale", 64'(stalls), 64'd0);
      bus_a.req_valid = 1'b1; bus_a.req_addr = 17'h61;
      @(negedge clk);
      check("mr_new_en", 64'(bus_a.ram_en), 64'd1);
      next_cycle();
      bus_a.req_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check($sformatf("mr_wait_rv%0d", c), 64'(bus_a.resp_valid), 64'd0);
         next_cycle();
      end
      @(negedge clk);
      check("mr_new_rv",   64'(bus_a.resp_valid), 64'd1);
      check("mr_new_data", bus_a.resp_data, pat(32'h61));
      $display("post-reset read: rv=%0d data=%h", bus_a.resp_valid, bus_a.resp_data);
      next_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
